// File: rtl/or10_tb_uart_wb_if.sv
// ============================================================================
// Module   : or10_tb_uart_wb_if
// Brief    : Wishbone bus (24-bit address, 32-bit data) for the OR10 UART target
// Revision : 1.0
// ============================================================================
`default_nettype none

interface or10_tb_uart_wb_if;
    logic [23:0] adr_i;
    logic [31:0] dat_i;
    logic [3:0]  sel_i;
    logic        we_i;
    logic        cyc_i;
    logic        stb_i;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        err_o;

    modport slave (
        input  adr_i, dat_i, sel_i, we_i, cyc_i, stb_i,
        output dat_o, ack_o, err_o
    );

    modport master (
        output adr_i, dat_i, sel_i, we_i, cyc_i, stb_i,
        input  dat_o, ack_o, err_o
    );
endinterface

`default_nettype wire

// File: rtl/or10_tb_uart_wb.sv
// ============================================================================
// Module   : or10_tb_uart_wb
// Brief    : 16550-subset UART Wishbone slave with TX/RX byte-stream FIFOs
// Revision : 1.0
// ============================================================================
`default_nettype none

module or10_tb_uart_wb #(
    parameter int TX_FIFO_AW    = 4,
    parameter int RX_FIFO_AW    = 4,
    parameter int TX_GAP_CYCLES = 8
) (
    input  wire logic        wb_clk_i,
    input  wire logic        wb_rst_n_i,
    or10_tb_uart_wb_if.slave wb,
    output logic             uart_int_o,
    output logic             tx_valid_o,
    output logic [7:0]       tx_data_o,
    input  wire logic        tx_ready_i,
    input  wire logic        rx_valid_i,
    input  wire logic [7:0]  rx_data_i,
    output logic             rx_ready_o
);

    localparam int TX_DEPTH = 1 << TX_FIFO_AW;
    localparam int RX_DEPTH = 1 << RX_FIFO_AW;
    localparam int TX_CW    = TX_FIFO_AW + 1;
    localparam int RX_CW    = RX_FIFO_AW + 1;
    localparam int GAP_W    = (TX_GAP_CYCLES > 0) ? $clog2(TX_GAP_CYCLES + 1) : 1;

    localparam logic [2:0] REG_DATA = 3'd0;
    localparam logic [2:0] REG_IER  = 3'd1;
    localparam logic [2:0] REG_IIR  = 3'd2;
    localparam logic [2:0] REG_LCR  = 3'd3;
    localparam logic [2:0] REG_LSR  = 3'd5;

    logic [7:0]            tx_mem_q [TX_DEPTH];
    logic [7:0]            rx_mem_q [RX_DEPTH];
    logic [TX_FIFO_AW-1:0] tx_rd_q, tx_wr_q;
    logic [RX_FIFO_AW-1:0] rx_rd_q, rx_wr_q;
    logic [TX_CW-1:0]      tx_cnt_q, tx_cnt_d;
    logic [RX_CW-1:0]      rx_cnt_q, rx_cnt_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [1:0]            ier_q;
    logic [7:0]            lcr_q;
    logic                  ack_q, err_q, int_q, rx_ready_q;
    logic [31:0]           dat_q;

    logic       req, addr_ok, wr_en, rd_en;
    logic [2:0] reg_k;
    logic [1:0] lane;
    logic [7:0] wr_byte, rd_byte;
    logic       tx_empty, tx_full, rx_empty;
    logic       tx_push, tx_pop, rx_push, rx_pop;
    logic       rx_pend, thr_pend;

    assign req     = wb.cyc_i & wb.stb_i & ~ack_q & ~err_q;
    assign addr_ok = (wb.adr_i[23:3] == 21'd0);
    assign reg_k   = wb.adr_i[2:0];
    // Big-endian lanes: register k lives in byte 3-(k&3).
    assign lane    = ~reg_k[1:0];
    assign wr_byte = wb.dat_i[{lane, 3'b000} +: 8];
    assign wr_en   = req & addr_ok & wb.we_i & wb.sel_i[lane];
    assign rd_en   = req & addr_ok & ~wb.we_i;

    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == TX_CW'(TX_DEPTH));
    assign rx_empty = (rx_cnt_q == '0);

    assign tx_valid_o = ~tx_empty & (gap_q == '0);
    assign tx_data_o  = tx_empty ? 8'h00 : tx_mem_q[tx_rd_q];
    assign tx_pop     = tx_valid_o & tx_ready_i;
    // A full FIFO still takes a THR write when the head leaves in the same cycle.
    assign tx_push    = wr_en & (reg_k == REG_DATA) & (~tx_full | tx_pop);

    assign rx_push = rx_valid_i & rx_ready_q;
    assign rx_pop  = rd_en & (reg_k == REG_DATA) & ~rx_empty;

    assign rx_pend  = ier_q[0] & ~rx_empty;
    assign thr_pend = ier_q[1] & tx_empty;

    always_comb begin
        rd_byte = 8'h00;
        case (reg_k)
            REG_DATA: rd_byte = rx_empty ? 8'h00 : rx_mem_q[rx_rd_q];
            REG_IER:  rd_byte = {6'd0, ier_q};
            REG_IIR:  rd_byte = rx_pend ? 8'hC4 : (thr_pend ? 8'hC2 : 8'hC1);
            REG_LCR:  rd_byte = lcr_q;
            REG_LSR:  rd_byte = {1'b0, tx_empty & ~tx_valid_o, tx_empty, 4'd0, ~rx_empty};
            default:  rd_byte = 8'h00;
        endcase
    end

    always_comb begin
        tx_cnt_d = tx_cnt_q + TX_CW'(tx_push) - TX_CW'(tx_pop);
        rx_cnt_d = rx_cnt_q + RX_CW'(rx_push) - RX_CW'(rx_pop);
        gap_d    = gap_q;
        if (tx_pop) begin
            gap_d = GAP_W'(TX_GAP_CYCLES);
        end else if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            tx_rd_q    <= '0;
            tx_wr_q    <= '0;
            tx_cnt_q   <= '0;
            rx_rd_q    <= '0;
            rx_wr_q    <= '0;
            rx_cnt_q   <= '0;
            gap_q      <= '0;
            ier_q      <= 2'b00;
            lcr_q      <= 8'h03;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dat_q      <= 32'd0;
            int_q      <= 1'b0;
            rx_ready_q <= 1'b1;
        end else begin
            ack_q    <= req & addr_ok;
            err_q    <= req & ~addr_ok;
            dat_q    <= rd_en ? {4{rd_byte}} : 32'd0;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            gap_q    <= gap_d;
            // Ready tracks the post-update count so it never lags a push/pop.
            rx_ready_q <= (rx_cnt_d != RX_CW'(RX_DEPTH));
            int_q      <= rx_pend | thr_pend;
            if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
            if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
            if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
            if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
            if (wr_en && reg_k == REG_IER) ier_q <= wr_byte[1:0];
            if (wr_en && reg_k == REG_LCR) lcr_q <= wr_byte;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_n_i && tx_push) tx_mem_q[tx_wr_q] <= wr_byte;
        if (wb_rst_n_i && rx_push) rx_mem_q[rx_wr_q] <= rx_data_i;
    end

    assign wb.dat_o   = dat_q;
    assign wb.ack_o   = ack_q;
    assign wb.err_o   = err_q;
    assign uart_int_o = int_q;
    assign rx_ready_o = rx_ready_q;

endmodule

`default_nettype wire
